// File: rtl/hart_control.sv
`default_nettype none
// ============================================================================
//  Module      : hart_control
//  Description : PC, fetch epoch, register file and busy scoreboard for the
//                core, with redirect, halt, read bypass and RAW/WAW interlock.
//  Revision    : 1.0 - initial release
// ============================================================================
module hart_control #(
    parameter int              XLEN     = 32,
    parameter int              NUM_REGS = 16,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              EPOCH_W  = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               halt,
    output logic               fetch_valid,
    input  logic               fetch_ready,
    output logic [XLEN-1:0]    fetch_pc,
    output logic [EPOCH_W-1:0] fetch_epoch,
    output logic [EPOCH_W-1:0] cur_epoch,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic [4:0]         rs1_addr,
    output logic [XLEN-1:0]    rs1_data,
    input  logic [4:0]         rs2_addr,
    output logic [XLEN-1:0]    rs2_data,
    input  logic               issue_valid,
    output logic               issue_ready,
    input  logic [4:0]         issue_rs1,
    input  logic [4:0]         issue_rs2,
    input  logic               issue_use_rs1,
    input  logic               issue_use_rs2,
    input  logic [4:0]         issue_rd,
    input  logic               issue_writes_rd,
    output logic               illegal_reg,
    input  logic               wb_valid,
    input  logic [4:0]         wb_rd,
    input  logic [XLEN-1:0]    wb_data
);

    localparam int              c_IDX_W    = $clog2(NUM_REGS);
    localparam logic [31:0]     c_NUM_REGS = NUM_REGS;
    localparam logic [XLEN-1:0] c_PC_STEP  = 4;

    logic [XLEN-1:0]    r_pc;
    logic [EPOCH_W-1:0] r_epoch;
    logic               r_fetch_valid;
    logic [XLEN-1:0]    r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;

    logic                w_fetch_fire;
    logic                w_wb_en;
    logic [NUM_REGS-1:0] w_wb_clr;
    logic [NUM_REGS-1:0] w_busy_eff;
    logic [NUM_REGS-1:0] w_busy_set;
    logic                w_illegal;
    logic                w_hazard;
    logic                w_issue_ready;
    logic                w_issue_fire;
    logic [XLEN-1:0]     w_rs1_data;
    logic [XLEN-1:0]     w_rs2_data;

    function automatic logic f_in_range(input logic [4:0] idx);
        return {27'd0, idx} < c_NUM_REGS;
    endfunction

    assign w_fetch_fire = r_fetch_valid && fetch_ready;
    assign w_wb_en      = wb_valid && (wb_rd != 5'd0) && f_in_range(wb_rd);

    always_comb begin
        w_wb_clr = '0;
        if (w_wb_en) begin
            w_wb_clr[wb_rd[c_IDX_W-1:0]] = 1'b1;
        end
    end

    // A writeback retiring this cycle already releases its register.
    assign w_busy_eff = r_busy & ~w_wb_clr;

    always_comb begin
        w_illegal = (issue_use_rs1   && !f_in_range(issue_rs1)) ||
                    (issue_use_rs2   && !f_in_range(issue_rs2)) ||
                    (issue_writes_rd && !f_in_range(issue_rd));
        w_hazard = 1'b0;
        if (issue_use_rs1 && f_in_range(issue_rs1) && w_busy_eff[issue_rs1[c_IDX_W-1:0]]) begin
            w_hazard = 1'b1;
        end
        if (issue_use_rs2 && f_in_range(issue_rs2) && w_busy_eff[issue_rs2[c_IDX_W-1:0]]) begin
            w_hazard = 1'b1;
        end
        if (issue_writes_rd && f_in_range(issue_rd) && w_busy_eff[issue_rd[c_IDX_W-1:0]]) begin
            w_hazard = 1'b1;
        end
    end

    assign w_issue_ready = !w_illegal && !w_hazard;
    assign w_issue_fire  = issue_valid && w_issue_ready && issue_writes_rd && (issue_rd != 5'd0);

    always_comb begin
        w_busy_set = '0;
        if (w_issue_fire) begin
            w_busy_set[issue_rd[c_IDX_W-1:0]] = 1'b1;
        end
    end

    always_comb begin
        w_rs1_data = r_regs[rs1_addr[c_IDX_W-1:0]];
        if (rs1_addr == 5'd0 || !f_in_range(rs1_addr)) begin
            w_rs1_data = '0;
        end else if (wb_valid && wb_rd == rs1_addr) begin
            w_rs1_data = wb_data;
        end
    end

    always_comb begin
        w_rs2_data = r_regs[rs2_addr[c_IDX_W-1:0]];
        if (rs2_addr == 5'd0 || !f_in_range(rs2_addr)) begin
            w_rs2_data = '0;
        end else if (wb_valid && wb_rd == rs2_addr) begin
            w_rs2_data = wb_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_epoch       <= '0;
            r_fetch_valid <= 1'b0;
            r_busy        <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            // Redirect wins over an accepted fetch; that request keeps the stale epoch.
            if (redirect_valid) begin
                r_pc    <= redirect_pc;
                r_epoch <= r_epoch + EPOCH_W'(1);
            end else if (w_fetch_fire) begin
                r_pc <= r_pc + c_PC_STEP;
            end
            if (!r_fetch_valid || w_fetch_fire) begin
                r_fetch_valid <= !halt;
            end
            if (w_wb_en) begin
                r_regs[wb_rd[c_IDX_W-1:0]] <= wb_data;
            end
            r_busy <= (r_busy & ~w_wb_clr) | w_busy_set;
        end
    end

    assign fetch_valid = r_fetch_valid;
    assign fetch_pc    = r_pc;
    assign fetch_epoch = r_epoch;
    assign cur_epoch   = r_epoch;
    assign rs1_data    = w_rs1_data;
    assign rs2_data    = w_rs2_data;
    assign issue_ready = w_issue_ready;
    assign illegal_reg = w_illegal;

endmodule
`default_nettype wire

// File: tb/tb_hart_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hart_control
//  Description : Scoreboard bench for hart_control, RV32E and RV32I side by side.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hart_control;

    typedef struct {
        bit          reset;
        bit          halt;
        bit          fetch_ready;
        bit          redirect_valid;
        logic [31:0] redirect_pc;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        bit          issue_valid;
        logic [4:0]  issue_rs1;
        logic [4:0]  issue_rs2;
        bit          issue_use_rs1;
        bit          issue_use_rs2;
        logic [4:0]  issue_rd;
        bit          issue_writes_rd;
        bit          wb_valid;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
    } stim_t;

    typedef struct {
        int          k;
        logic        fv;
        logic [31:0] fpc;
        logic [1:0]  fep;
        logic [1:0]  cep;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        rdy;
        logic        ill;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        halt = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rs1 = '0;
    logic [4:0]  issue_rs2 = '0;
    logic        issue_use_rs1 = 1'b0;
    logic        issue_use_rs2 = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_writes_rd = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;

    logic        o_fv  [2];
    logic [31:0] o_fpc [2];
    logic [1:0]  o_fep [2];
    logic [1:0]  o_cep [2];
    logic [31:0] o_r1  [2];
    logic [31:0] o_r2  [2];
    logic        o_rdy [2];
    logic        o_ill [2];

    always #5 clock = ~clock;

    hart_control #(.XLEN(32), .NUM_REGS(16), .RESET_PC(32'h0), .EPOCH_W(2)) dut16 (
        .clock(clock), .reset(reset), .halt(halt),
        .fetch_valid(o_fv[0]), .fetch_ready(fetch_ready), .fetch_pc(o_fpc[0]),
        .fetch_epoch(o_fep[0]), .cur_epoch(o_cep[0]),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .rs1_addr(rs1_addr), .rs1_data(o_r1[0]), .rs2_addr(rs2_addr), .rs2_data(o_r2[0]),
        .issue_valid(issue_valid), .issue_ready(o_rdy[0]),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
        .issue_rd(issue_rd), .issue_writes_rd(issue_writes_rd), .illegal_reg(o_ill[0]),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    hart_control #(.XLEN(32), .NUM_REGS(32), .RESET_PC(32'h0), .EPOCH_W(2)) dut32 (
        .clock(clock), .reset(reset), .halt(halt),
        .fetch_valid(o_fv[1]), .fetch_ready(fetch_ready), .fetch_pc(o_fpc[1]),
        .fetch_epoch(o_fep[1]), .cur_epoch(o_cep[1]),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .rs1_addr(rs1_addr), .rs1_data(o_r1[1]), .rs2_addr(rs2_addr), .rs2_data(o_r2[1]),
        .issue_valid(issue_valid), .issue_ready(o_rdy[1]),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
        .issue_rd(issue_rd), .issue_writes_rd(issue_writes_rd), .illegal_reg(o_ill[1]),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    // Architectural reference state: one copy per register-count configuration.
    int          nregs [2] = '{16, 32};
    logic [31:0] m_pc;
    int          m_ep;
    bit          m_fv;
    logic [31:0] m_regs [2][32];
    bit          m_busy [2][32];

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    function automatic bit legal(int k, logic [4:0] a);
        return int'(a) < nregs[k];
    endfunction

    function automatic bit wb_hits(int k, stim_t s, logic [4:0] a);
        return s.wb_valid && s.wb_rd == a && a != 0 && legal(k, a);
    endfunction

    function automatic logic [31:0] read_reg(int k, stim_t s, logic [4:0] a);
        if (a == 0 || !legal(k, a)) return 32'h0;
        if (s.wb_valid && s.wb_rd == a) return s.wb_data;
        return m_regs[k][a];
    endfunction

    function automatic bit is_illegal(int k, stim_t s);
        return (s.issue_use_rs1 && !legal(k, s.issue_rs1)) ||
               (s.issue_use_rs2 && !legal(k, s.issue_rs2)) ||
               (s.issue_writes_rd && !legal(k, s.issue_rd));
    endfunction

    function automatic bit busy_now(int k, stim_t s, logic [4:0] a);
        return m_busy[k][a] && !wb_hits(k, s, a);
    endfunction

    function automatic bit is_ready(int k, stim_t s);
        if (is_illegal(k, s)) return 1'b0;
        if (s.issue_use_rs1 && busy_now(k, s, s.issue_rs1)) return 1'b0;
        if (s.issue_use_rs2 && busy_now(k, s, s.issue_rs2)) return 1'b0;
        if (s.issue_writes_rd && busy_now(k, s, s.issue_rd)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.fetch_ready = 1'b1;
        return s;
    endfunction

    task automatic drive(input stim_t s, input bit chk);
        bit hs;
        bit rdy [2];
        @(negedge clock);
        reset = s.reset; halt = s.halt; fetch_ready = s.fetch_ready;
        redirect_valid = s.redirect_valid; redirect_pc = s.redirect_pc;
        rs1_addr = s.rs1_addr; rs2_addr = s.rs2_addr;
        issue_valid = s.issue_valid; issue_rs1 = s.issue_rs1; issue_rs2 = s.issue_rs2;
        issue_use_rs1 = s.issue_use_rs1; issue_use_rs2 = s.issue_use_rs2;
        issue_rd = s.issue_rd; issue_writes_rd = s.issue_writes_rd;
        wb_valid = s.wb_valid; wb_rd = s.wb_rd; wb_data = s.wb_data;
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            rdy[k] = is_ready(k, s);
            e.k = k; e.fv = m_fv; e.fpc = m_pc; e.fep = 2'(m_ep); e.cep = 2'(m_ep);
            e.r1 = read_reg(k, s, s.rs1_addr); e.r2 = read_reg(k, s, s.rs2_addr);
            e.rdy = rdy[k]; e.ill = is_illegal(k, s);
            if (chk) q.push_back(e);
        end
        hs = m_fv && s.fetch_ready;
        if (s.reset) begin
            m_pc = 32'h0; m_ep = 0; m_fv = 1'b0;
            for (int k = 0; k < 2; k++)
                for (int r = 0; r < 32; r++) begin
                    m_regs[k][r] = 32'h0; m_busy[k][r] = 1'b0;
                end
        end else begin
            if (s.redirect_valid) begin
                m_pc = s.redirect_pc; m_ep = (m_ep + 1) % 4;
            end else if (hs) begin
                m_pc = m_pc + 32'd4;
            end
            if (!m_fv || hs) m_fv = !s.halt;
            for (int k = 0; k < 2; k++) begin
                if (wb_hits(k, s, s.wb_rd)) begin
                    m_regs[k][s.wb_rd] = s.wb_data; m_busy[k][s.wb_rd] = 1'b0;
                end
                if (s.issue_valid && rdy[k] && s.issue_writes_rd && s.issue_rd != 0)
                    m_busy[k][s.issue_rd] = 1'b1;
            end
        end
    endtask

    task automatic cmp(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[cfg%0d] got=%h expected=%h at %0t", name, nregs[k], act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            #2;
            while (q.size() > 0) begin
                exp_t e;
                int k;
                e = q.pop_front();
                k = e.k;
                cmp("fetch_valid", k, 32'(o_fv[k]), 32'(e.fv));
                if (e.fv) begin
                    cmp("fetch_pc", k, o_fpc[k], e.fpc);
                    cmp("fetch_epoch", k, 32'(o_fep[k]), 32'(e.fep));
                end
                cmp("cur_epoch", k, 32'(o_cep[k]), 32'(e.cep));
                cmp("rs1_data", k, o_r1[k], e.r1);
                cmp("rs2_data", k, o_r2[k], e.r2);
                cmp("issue_ready", k, 32'(o_rdy[k]), 32'(e.rdy));
                cmp("illegal_reg", k, 32'(o_ill[k]), 32'(e.ill));
            end
        end
    end

    function automatic logic [4:0] rand_idx();
        if ($urandom_range(0, 9) < 8) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        stim_t s;
        s = idle(); s.reset = 1'b1;
        drive(s, 1'b0);
        drive(s, 1'b1);
        // Fetch stream, stall, redirect on an accepted fetch, epoch wrap.
        drive(idle(), 1'b1);
        drive(idle(), 1'b1);
        drive(idle(), 1'b1);
        s = idle(); s.fetch_ready = 1'b0;
        repeat (3) drive(s, 1'b1);
        drive(idle(), 1'b1);
        drive(idle(), 1'b1);
        s = idle(); s.redirect_valid = 1'b1; s.redirect_pc = 32'h100;
        drive(s, 1'b1);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.redirect_valid = 1'b1; s.redirect_pc = 32'h200 + 32'(i * 16);
            drive(s, 1'b1);
        end
        drive(idle(), 1'b1);
        // Halt mid-request, then PC wrap at the top of the address space.
        s = idle(); s.halt = 1'b1; s.fetch_ready = 1'b0;
        drive(s, 1'b1);
        s.fetch_ready = 1'b1;
        repeat (3) drive(s, 1'b1);
        s = idle(); s.redirect_valid = 1'b1; s.redirect_pc = 32'hFFFF_FFFC;
        drive(s, 1'b1);
        repeat (3) drive(idle(), 1'b1);
        // Bypass and x0.
        s = idle(); s.wb_valid = 1'b1; s.wb_rd = 5'd5; s.wb_data = 32'hDEAD; s.rs1_addr = 5'd5;
        drive(s, 1'b1);
        s = idle(); s.rs1_addr = 5'd5; s.rs2_addr = 5'd5;
        drive(s, 1'b1);
        s = idle(); s.wb_valid = 1'b1; s.wb_rd = 5'd0; s.wb_data = 32'h7;
        drive(s, 1'b1);
        // RAW interlock on x3, released in the writeback cycle, re-claimed by a same-cycle issue.
        s = idle(); s.issue_valid = 1'b1; s.issue_writes_rd = 1'b1; s.issue_rd = 5'd3;
        drive(s, 1'b1);
        s = idle(); s.issue_valid = 1'b1; s.issue_use_rs1 = 1'b1; s.issue_rs1 = 5'd3;
        repeat (2) drive(s, 1'b1);
        s.wb_valid = 1'b1; s.wb_rd = 5'd3; s.wb_data = 32'h33; s.issue_writes_rd = 1'b1; s.issue_rd = 5'd3;
        drive(s, 1'b1);
        s = idle(); s.issue_valid = 1'b1; s.issue_use_rs1 = 1'b1; s.issue_rs1 = 5'd3;
        drive(s, 1'b1);
        s = idle(); s.wb_valid = 1'b1; s.wb_rd = 5'd3; s.wb_data = 32'h34;
        drive(s, 1'b1);
        // Source index beyond the RV32E range.
        s = idle(); s.issue_valid = 1'b1; s.issue_use_rs2 = 1'b1; s.issue_rs2 = 5'd20; s.rs2_addr = 5'd20;
        drive(s, 1'b1);
        // Randomised traffic with a reset in the middle.
        for (int i = 0; i < 1500; i++) begin
            s = idle();
            s.reset = (i == 700);
            s.halt = ($urandom_range(0, 9) == 0);
            s.fetch_ready = ($urandom_range(0, 9) < 7);
            s.redirect_valid = ($urandom_range(0, 11) == 0);
            s.redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            s.rs1_addr = rand_idx(); s.rs2_addr = rand_idx();
            s.issue_valid = ($urandom_range(0, 9) < 6);
            s.issue_rs1 = rand_idx(); s.issue_rs2 = rand_idx(); s.issue_rd = rand_idx();
            s.issue_use_rs1 = 1'($urandom_range(0, 1));
            s.issue_use_rs2 = 1'($urandom_range(0, 1));
            s.issue_writes_rd = ($urandom_range(0, 9) < 6);
            s.wb_valid = ($urandom_range(0, 9) < 4);
            s.wb_rd = rand_idx(); s.wb_data = $urandom;
            drive(s, 1'b1);
        end
        repeat (3) @(negedge clock);
        #4;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
